// File: rtl/spi_flash_reader_pkg.sv
// Shared constants, FSM state type and command-frame helper for the SPI flash read master.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam int         ADDR_W   = 24;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        PWR_UP = 3'd1,
        IDLE   = 3'd2,
        CMD    = 3'd3,
        DATA   = 3'd4,
        STALL  = 3'd5,
        DESEL  = 3'd6
    } state_t;

    function automatic logic [31:0] read_frame(input logic [ADDR_W-1:0] addr);
        return {CMD_READ, addr};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: SPI_CLK idles low while disabled, toggles every CLK_DIV cycles when enabled,
// and flags the CLKA edges that will drive it high (rise_en) or low (fall_en).
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic CLKA,
    input  logic RST,
    input  logic en,
    output logic sclk,
    output logic rise_en,
    output logic fall_en
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_r;
    logic             sclk_r;
    logic             term_s;

    assign term_s  = (cnt_r == CNT_W'(CLK_DIV - 1));
    assign rise_en = en && term_s && !sclk_r;
    assign fall_en = en && term_s && sclk_r;
    assign sclk    = sclk_r;

    // Half-period counter; disabling restarts it so the first rise is a full half-period away
    always_ff @(posedge CLKA) begin
        if (RST) begin
            cnt_r  <= {CNT_W{1'b0}};
            sclk_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= {CNT_W{1'b0}};
            sclk_r <= 1'b0;
        end else if (term_s) begin
            cnt_r  <= {CNT_W{1'b0}};
            sclk_r <= !sclk_r;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master: powers the memory, sends READ + 24-bit address, then streams bytes
// to a valid/ready consumer, pausing the serial clock at byte boundaries when backpressured.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int PWR_UP_CYCLES = 200,
    parameter int DESEL_CYCLES  = 4,
    parameter int LEN_W         = 16
) (
    input  logic              CLKA,
    input  logic              RST,
    input  logic              start,
    input  logic [23:0]       start_addr,
    input  logic [LEN_W-1:0]  byte_count,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              MEM_VCC,
    output logic              SPI_CLK,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO,
    output logic              SPI_CS_n
);

    localparam int WAIT_MAX   = (PWR_UP_CYCLES > DESEL_CYCLES) ? PWR_UP_CYCLES : DESEL_CYCLES;
    localparam int WAIT_W     = $clog2(WAIT_MAX + 1);
    localparam int PWR_LAST   = (PWR_UP_CYCLES > 0) ? PWR_UP_CYCLES - 1 : 0;
    localparam int DESEL_LAST = (DESEL_CYCLES > 0) ? DESEL_CYCLES - 1 : 0;

    state_t             state_r;
    state_t             state_nx_s;
    logic [31:0]        frame_s;
    logic [31:0]        sh_r;
    logic [6:0]         rx_r;
    logic [4:0]         bit_cnt_r;
    logic [LEN_W-1:0]   remain_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [7:0]         rd_data_r;
    logic               rd_valid_r;
    logic               mem_vcc_r;
    logic               mosi_r;
    logic               cs_n_r;
    logic               sclk_en_s;
    logic               active_nx_s;
    logic               load_s;
    logic               rise_s;
    logic               fall_s;
    logic               sclk_s;

    assign frame_s     = read_frame(start_addr);
    assign sclk_en_s   = (state_r == CMD) || (state_r == DATA);
    assign active_nx_s = (state_nx_s == CMD) || (state_nx_s == DATA) || (state_nx_s == STALL);
    assign load_s      = (state_r == DATA) && rise_s && (bit_cnt_r == 5'd7);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .CLKA    (CLKA),
        .RST     (RST),
        .en      (sclk_en_s),
        .sclk    (sclk_s),
        .rise_en (rise_s),
        .fall_en (fall_s)
    );

    // State register
    always_ff @(posedge CLKA) begin
        if (RST) begin
            state_r <= OFF;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; byte boundaries are the SPI_CLK falls that close a byte
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            OFF: begin
                state_nx_s = PWR_UP;
            end
            PWR_UP: begin
                if (wait_cnt_r == WAIT_W'(PWR_LAST)) state_nx_s = IDLE;
                else                                 state_nx_s = PWR_UP;
            end
            IDLE: begin
                if (start && (byte_count != {LEN_W{1'b0}})) state_nx_s = CMD;
                else                                        state_nx_s = IDLE;
            end
            CMD: begin
                if (fall_s && (bit_cnt_r == 5'd31)) state_nx_s = DATA;
                else                                state_nx_s = CMD;
            end
            DATA: begin
                if (fall_s && (bit_cnt_r == 5'd0)) begin
                    if (remain_r == {LEN_W{1'b0}})      state_nx_s = DESEL;
                    else if (rd_valid_r && !rd_ready)   state_nx_s = STALL;
                    else                                state_nx_s = DATA;
                end else begin
                    state_nx_s = DATA;
                end
            end
            STALL: begin
                if (!rd_valid_r || rd_ready) state_nx_s = DATA;
                else                         state_nx_s = STALL;
            end
            DESEL: begin
                if ((wait_cnt_r >= WAIT_W'(DESEL_LAST)) && !rd_valid_r) state_nx_s = IDLE;
                else                                                     state_nx_s = DESEL;
            end
            default: begin
                state_nx_s = OFF;
            end
        endcase
    end

    // Pin drivers, command shifter, receive shifter and transfer bookkeeping
    always_ff @(posedge CLKA) begin
        if (RST) begin
            mem_vcc_r  <= 1'b0;
            cs_n_r     <= 1'b1;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sh_r       <= 32'd0;
            rx_r       <= 7'd0;
            bit_cnt_r  <= 5'd0;
            remain_r   <= {LEN_W{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            mem_vcc_r <= (state_nx_s != OFF);
            cs_n_r    <= !active_nx_s;
            done_r    <= 1'b0;
            if (state_nx_s != state_r) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if (wait_cnt_r != {WAIT_W{1'b1}}) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
            case (state_r)
                IDLE: begin
                    if (start && (byte_count != {LEN_W{1'b0}})) begin
                        sh_r      <= {frame_s[30:0], 1'b0};
                        mosi_r    <= frame_s[31];
                        remain_r  <= byte_count;
                        bit_cnt_r <= 5'd0;
                        busy_r    <= 1'b1;
                    end else if (start) begin
                        done_r    <= 1'b1;
                    end
                end
                CMD: begin
                    // the 32nd fall shifts out the zero fill, leaving MOSI low for DATA
                    if (fall_s) begin
                        mosi_r    <= sh_r[31];
                        sh_r      <= {sh_r[30:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                    end
                end
                DATA: begin
                    if (rise_s) begin
                        rx_r <= {rx_r[5:0], SPI_MISO};
                        if (bit_cnt_r == 5'd7) begin
                            bit_cnt_r <= 5'd0;
                            remain_r  <= remain_r - LEN_W'(1);
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                DESEL: begin
                    if (state_nx_s == IDLE) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output byte register; a new byte may land in the same cycle the old one is taken
    always_ff @(posedge CLKA) begin
        if (RST) begin
            rd_data_r  <= 8'd0;
            rd_valid_r <= 1'b0;
        end else if (load_s) begin
            rd_data_r  <= {rx_r, SPI_MISO};
            rd_valid_r <= 1'b1;
        end else if (rd_ready) begin
            rd_valid_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign MEM_VCC  = mem_vcc_r;
    assign SPI_CLK  = sclk_s;
    assign SPI_MOSI = mosi_r;
    assign SPI_CS_n = cs_n_r;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: behavioural SPI memory model plus per-transfer
// expectations derived from the bit-level protocol (frame contents, clock counts, byte order).
module tb_spi_flash_reader;

    localparam int CLK_DIV       = 2;
    localparam int PWR_UP_CYCLES = 200;
    localparam int DESEL_CYCLES  = 4;
    localparam int LEN_W         = 16;

    logic              CLKA       = 1'b0;
    logic              RST        = 1'b1;
    logic              start      = 1'b0;
    logic [23:0]       start_addr = 24'd0;
    logic [LEN_W-1:0]  byte_count = 16'd0;
    logic              rd_ready   = 1'b1;
    logic              SPI_MISO   = 1'b0;
    logic              busy, done, rd_valid, MEM_VCC, SPI_CLK, SPI_MOSI, SPI_CS_n;
    logic [7:0]        rd_data;

    always #5 CLKA = ~CLKA;

    spi_flash_reader #(
        .CLK_DIV       (CLK_DIV),
        .PWR_UP_CYCLES (PWR_UP_CYCLES),
        .DESEL_CYCLES  (DESEL_CYCLES),
        .LEN_W         (LEN_W)
    ) dut (
        .CLKA       (CLKA),
        .RST        (RST),
        .start      (start),
        .start_addr (start_addr),
        .byte_count (byte_count),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .MEM_VCC    (MEM_VCC),
        .SPI_CLK    (SPI_CLK),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_MISO   (SPI_MISO),
        .SPI_CS_n   (SPI_CS_n)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // memory model state: bytes it will return, captured command frame, protocol counters
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] cmd_cap     = 32'd0;
    logic [7:0]  cur_byte    = 8'd0;
    logic        cs_prev     = 1'b1;
    logic        clk_prev    = 1'b0;
    int          sbit        = 0;
    int          bidx        = 0;
    int          rises       = 0;
    int          mosi_bad    = 0;
    int          sclk_hi_bad = 0;
    int          cs_falls    = 0;
    int          cs_low_cyc  = 0;
    int          done_cnt    = 0;

    // SPI memory: captures 32 command bits on rises, then returns exp_q bytes MSB first
    always @(SPI_CLK or SPI_CS_n) begin
        if (SPI_CS_n === 1'b0 && cs_prev === 1'b1) begin
            sbit = 0;
            cmd_cap = 32'd0;
            cs_falls++;
        end
        if (SPI_CLK === 1'b1 && clk_prev === 1'b0) begin
            if (SPI_CS_n !== 1'b0) begin
                sclk_hi_bad++;
            end else begin
                rises++;
                if (sbit < 32) cmd_cap = {cmd_cap[30:0], SPI_MOSI};
                else if (SPI_MOSI !== 1'b0) mosi_bad++;
                sbit++;
            end
        end
        if (SPI_CLK === 1'b0 && clk_prev === 1'b1 && SPI_CS_n === 1'b0 && sbit >= 32) begin
            bidx = (sbit - 32) / 8;
            cur_byte = (bidx < exp_q.size()) ? exp_q[bidx] : 8'h00;
            SPI_MISO = cur_byte[7 - ((sbit - 32) % 8)];
        end
        cs_prev  = SPI_CS_n;
        clk_prev = SPI_CLK;
    end

    // Consumer-side monitor, sampled mid-cycle
    always @(negedge CLKA) begin
        if (SPI_CS_n === 1'b0) cs_low_cyc++;
        if (done === 1'b1) done_cnt++;
        if (rd_valid === 1'b1 && rd_ready === 1'b1) got_q.push_back(rd_data);
    end

    task automatic tick();
        @(posedge CLKA);
        #1;
    endtask

    // mode: 0 always ready, 1 random ready, 2 long stall after first byte, 3 extra start while busy
    task automatic run_xfer(input logic [23:0] addr, input int n, input int mode,
                            input logic [7:0] b0, input logic [7:0] b1);
        int cyc, limit, stall_left, stall_bad, nb;
        int r0, mb0, sh0, cf0, cl0, d0, g0;
        bit seen, stalled;
        logic [7:0] b;
        cyc = 0; stall_left = 0; stall_bad = 0; seen = 1'b0; stalled = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (i == 0 && mode == 0) b = b0;
            if (i == 1 && mode == 0) b = b1;
            exp_q.push_back(b);
        end
        r0 = rises; mb0 = mosi_bad; sh0 = sclk_hi_bad; cf0 = cs_falls;
        cl0 = cs_low_cyc; d0 = done_cnt; g0 = got_q.size();
        rd_ready = 1'b1; start_addr = addr; byte_count = 16'(n); start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        limit = (32 + 8 * n) * 2 * CLK_DIV + 300;
        while (!seen && cyc < limit) begin
            tick();
            cyc++;
            if (done === 1'b1) seen = 1'b1;
            case (mode)
                1: rd_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!stalled && rd_valid === 1'b1) begin
                        stalled = 1'b1;
                        stall_left = 50;
                    end
                    if (stall_left > 0) begin
                        if (stall_left <= 45 && !(SPI_CLK === 1'b0 && SPI_CS_n === 1'b0)) stall_bad++;
                        rd_ready = 1'b0;
                        stall_left--;
                    end else begin
                        rd_ready = 1'b1;
                    end
                end
                3: start = (cyc == 40);
                default: rd_ready = 1'b1;
            endcase
        end
        start = 1'b0;
        rd_ready = 1'b1;
        check("done_seen", seen, 1'b1);
        repeat (8) tick();
        nb = got_q.size() - g0;
        check("bytes_received", nb, n);
        for (int i = 0; i < n && i < nb; i++) check("rx_byte", got_q[g0 + i], exp_q[i]);
        check("mosi_frame", cmd_cap, {8'h03, addr});
        check("sclk_rises", rises - r0, 32 + 8 * n);
        check("mosi_zero_in_data", mosi_bad - mb0, 0);
        check("sclk_while_deselected", sclk_hi_bad - sh0, 0);
        check("done_pulses", done_cnt - d0, 1);
        check("cs_falls", cs_falls - cf0, 1);
        check("busy_end", busy, 1'b0);
        check("cs_high_end", SPI_CS_n, 1'b1);
        if (mode == 0) check("cs_low_cycles", cs_low_cyc - cl0, (32 + 8 * n) * 2 * CLK_DIV);
        if (mode == 2) begin
            check("stall_seen", stalled, 1'b1);
            check("stall_clk_low_cs_low", stall_bad, 0);
        end
    endtask

    int cf_snap;

    initial begin
        // reset values
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_mem_vcc", MEM_VCC, 1'b0);
        check("rst_sclk", SPI_CLK, 1'b0);
        check("rst_mosi", SPI_MOSI, 1'b0);
        check("rst_cs_n", SPI_CS_n, 1'b1);

        // power-up window: supply on after one edge, starts ignored until it elapses
        RST = 1'b0;
        tick();
        check("pwr_mem_vcc", MEM_VCC, 1'b1);
        repeat (98) tick();
        start_addr = 24'h123456; byte_count = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("pwr_start100_busy", busy, 1'b0);
        check("pwr_start100_cs", SPI_CS_n, 1'b1);
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pwr_last_cycle_busy", busy, 1'b0);

        // directed read: first start after power-up is accepted
        run_xfer(24'h000100, 2, 0, 8'hA5, 8'h3C);

        // zero-length request
        cf_snap = cs_falls;
        byte_count = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_cs", SPI_CS_n, 1'b1);
        check("zero_sclk", SPI_CLK, 1'b0);
        tick();
        check("zero_done_once", done, 1'b0);
        check("zero_busy2", busy, 1'b0);
        check("zero_no_cs_fall", cs_falls - cf_snap, 0);

        run_xfer(24'($urandom), 3, 2, 8'h00, 8'h00);
        run_xfer(24'($urandom), 2, 3, 8'h00, 8'h00);
        for (int t = 0; t < 6; t++) run_xfer(24'($urandom), $urandom_range(1, 5), 1, 8'h00, 8'h00);
        run_xfer(24'hFFFFFF, 3, 0, 8'h81, 8'h7E);

        // reset in the middle of the data phase
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom));
        rd_ready = 1'b1; start_addr = 24'h0ABCDE; byte_count = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (150) tick();
        check("mid_data_cs_low", SPI_CS_n, 1'b0);
        RST = 1'b1;
        tick();
        check("midrst_cs_n", SPI_CS_n, 1'b1);
        check("midrst_sclk", SPI_CLK, 1'b0);
        check("midrst_rd_valid", rd_valid, 1'b0);
        check("midrst_mem_vcc", MEM_VCC, 1'b0);
        check("midrst_busy", busy, 1'b0);
        RST = 1'b0;
        tick();
        check("repwr_mem_vcc", MEM_VCC, 1'b1);
        repeat (205) tick();
        run_xfer(24'($urandom), 4, 0, 8'h5A, 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- SPI-mode-0 master that powers up the external serial memory, issues a READ (0x03) command with a 24-bit address, and streams N data bytes out through a valid/ready byte interface.
- Sits between the SPI pins of top (MEM_VCC, SPI_CLK, SPI_MOSI, SPI_MISO, SPI_CS_n) and the downstream FIFO write logic.
- Single clock domain. SPI_CLK is derived by counter from CLKA.

Parameters:
- CLK_DIV, 2: SPI_CLK half-period in CLKA cycles (>=1).
- PWR_UP_CYCLES, 200: CLKA cycles from MEM_VCC rising to first CS_n low.
- DESEL_CYCLES, 4: minimum CLKA cycles CS_n stays high after a transfer.
- LEN_W, 16: width of byte_count.

Ports:
- CLKA  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  24  first memory address.
- byte_count  in  LEN_W  number of bytes to read.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of transfer.
- rd_data  out  8  received byte, MSB first on the wire.
- rd_valid  out  1  rd_data holds an unconsumed byte.
- rd_ready  in  1  consumer accepts when rd_valid&&rd_ready.
- MEM_VCC  out  1  memory supply enable.
- SPI_CLK  out  1  serial clock, idle low.
- SPI_MOSI  out  1  serial data to memory.
- SPI_MISO  in  1  serial data from memory.
- SPI_CS_n  out  1  chip select, active low.

Behaviour:
- Reset values: busy=0, done=0, rd_valid=0, rd_data=0, MEM_VCC=0, SPI_CLK=0, SPI_MOSI=0, SPI_CS_n=1. State=OFF.
- Reset mid-transfer takes effect next edge: CS_n high and SPI_CLK low at once, and power-up is redone.
- States:
  - OFF: MEM_VCC=0; go to PWR_UP next cycle.
  - PWR_UP: MEM_VCC=1; count PWR_UP_CYCLES, then go to IDLE. start is ignored here and busy=0.
  - IDLE: start with byte_count!=0 latches addr/count, sets busy, goes to CMD.
  - start with byte_count==0 gives done=1 the next cycle. CS_n is not toggled and busy is never asserted.
  - CMD: CS_n low; shift 32 bits {0x03, start_addr} MSB first, then go to DATA.
  - DATA: shift in 8 bits per byte. On the 8th rising SPI_CLK edge, load rd_data, set rd_valid, and decrement the remaining count.
  - Remaining count reaching 0 goes to DESEL.
  - STALL: entered at a byte boundary when rd_valid && !rd_ready. SPI_CLK holds low and CS_n stays low; resume when the byte is accepted.
  - DESEL: CS_n high, SPI_CLK low; wait DESEL_CYCLES and until rd_valid==0, then pulse done, clear busy, go to IDLE.
- SPI timing (mode 0):
  - SPI_MOSI updates on the CLKA edge that drives SPI_CLK low, or at CS_n fall for bit 0.
  - SPI_MISO is sampled on the CLKA edge that drives SPI_CLK high.
  - Each bit takes 2*CLK_DIV CLKA cycles.
  - The first SPI_CLK rise occurs CLK_DIV cycles after CS_n falls.
- MOSI is 0 during DATA.
- No SPI_CLK edges occur while CS_n is high.
- rd_valid clears on the handshake. A new byte may load on the same cycle as the handshake.
- Address wrap above 0xFFFFFF is left to the memory; the block only counts bytes.
- start while busy is ignored.

Decomposition:
- Package spi_flash_pkg holds:
  - CMD_READ=8'h03
  - state enum {OFF,PWR_UP,IDLE,CMD,DATA,STALL,DESEL}
  - ADDR_W=24
- One sub-module, spi_clk_gen: divider counter producing SPI_CLK plus one-cycle rise_en/fall_en strobes, gated by an enable from the FSM.

Test Plan:
- After reset with PWR_UP_CYCLES=200: MEM_VCC=1 one cycle after RST falls. A start issued at cycle 100 is ignored, with busy=0. A start after cycle 201 is accepted.
- Read addr=0x000100, count=2, MISO drives 0xA5 then 0x3C, rd_ready=1:
  - MOSI carries 0x03,0x00,0x01,0x00.
  - rd_data 0xA5 then 0x3C arrive with one rd_valid each.
  - CS_n is low for exactly 48 SPI_CLK periods (192 CLKA cycles at CLK_DIV=2).
  - done pulses once.
- count=3 with rd_ready=0 for 50 cycles after the first byte: SPI_CLK stays low with CS_n low during the stall. All bytes are received in order with none lost or duplicated.
- count=0: done pulses the next cycle; CS_n, SPI_CLK and busy do not change.
- RST asserted mid-DATA: next cycle CS_n=1, SPI_CLK=0, rd_valid=0, MEM_VCC=0. A subsequent full power-up and read completes correctly.
- start pulsed again while busy: ignored. Exactly one transfer completes and one done pulse occurs.
